// File: rtl/alu_cmd_issuer.sv
// Command front-end for the 8-bit accumulator ALU: buffers commands in a FIFO, issues them one at a
// time onto the ALU selector/operand inputs and returns each result with an error flag.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_op_i,
  input  logic [1:0]                 cmd_src_i,
  input  logic [7:0]                 cmd_a_i,
  input  logic [7:0]                 cmd_b_i,
  output logic [7:0]                 num1_o,
  output logic [7:0]                 num2_o,
  output logic [2:0]                 in_selector_o,
  output logic [6:0]                 out_selector_o,
  input  logic [7:0]                 alu_result_i,
  input  logic                       alu_overflow_i,
  output logic                       res_valid_o,
  output logic [7:0]                 res_data_o,
  output logic                       res_error_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned LatW = $clog2(RESULT_LAT + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StError = 2'b11
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] src;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t                mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  state_e              state_q, state_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic                res_valid_q, res_valid_d;
  logic [7:0]          res_data_q, res_data_d;
  logic                res_error_q, res_error_d;
  logic [2:0]          op_q;
  logic [1:0]          src_q;
  logic [7:0]          a_q, b_q;

  logic full, empty, push, pop, invalid, err;
  cmd_t head;

  assign full        = (count_q == CntW'(DEPTH));
  assign empty       = (count_q == '0);
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  assign head        = mem_q[rd_ptr_q];

  assign invalid = (op_q == 3'd7) || (src_q == 2'd3);
  assign err     = invalid || ((op_q == 3'd6) && alu_overflow_i);

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    pop         = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        lat_d   = LatW'(RESULT_LAT);
        state_d = StWait;
      end
      StWait: begin
        lat_d = lat_q - LatW'(1);
        if (lat_q == LatW'(1)) begin
          res_valid_d = 1'b1;
          res_data_d  = invalid ? 8'h00 : alu_result_i;
          res_error_d = err;
          if (err) begin
            state_d = StError;
          end else if (!empty) begin
            // Back-to-back issue: the next command skips IDLE
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    num1_o         = 8'h00;
    num2_o         = 8'h00;
    in_selector_o  = 3'b000;
    out_selector_o = 7'b0000000;
    unique case (state_q)
      StIssue, StWait: begin
        num1_o = a_q;
        num2_o = b_q;
        unique case (src_q)
          2'd0:    in_selector_o = 3'b100;
          2'd1:    in_selector_o = 3'b010;
          2'd2:    in_selector_o = 3'b001;
          default: in_selector_o = 3'b000;
        endcase
        if (op_q != 3'd7) out_selector_o = 7'(1) << op_q;
      end
      StError: in_selector_o = 3'b001;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op_i, src: cmd_src_i, a: cmd_a_i, b: cmd_b_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_error_q <= 1'b0;
      op_q        <= 3'd0;
      src_q       <= 2'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        op_q     <= head.op;
        src_q    <= head.src;
        a_q      <= head.a;
        b_q      <= head.b;
      end
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_error_o  = res_error_q;
  assign state_o      = state_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized bench for alu_cmd_issuer: a schedule model predicts each command's issue cycle from
// its accept cycle, and the bench plays the ALU with per-cycle random result/overflow tables.
module tb_alu_cmd_issuer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RL    = 1;
  localparam int          TblSz = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_src;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] num1, num2;
  logic [2:0] in_sel;
  logic [6:0] out_sel;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_error;
  logic [1:0] state;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .RESULT_LAT(RL)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_op_i       (cmd_op),
    .cmd_src_i      (cmd_src),
    .cmd_a_i        (cmd_a),
    .cmd_b_i        (cmd_b),
    .num1_o         (num1),
    .num2_o         (num2),
    .in_selector_o  (in_sel),
    .out_selector_o (out_sel),
    .alu_result_i   (alu_result),
    .alu_overflow_i (alu_overflow),
    .res_valid_o    (res_valid),
    .res_data_o     (res_data),
    .res_error_o    (res_error),
    .state_o        (state),
    .fifo_count_o   (fifo_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         accept;
    int         issue;
    logic [2:0] op;
    logic [1:0] src;
    logic [7:0] a;
    logic [7:0] b;
    bit         err;
    logic [7:0] data;
  } mcmd_t;

  mcmd_t      q[$];
  logic [7:0] res_tbl [TblSz];
  bit         ovf_tbl [TblSz];

  function automatic logic [2:0] src_onehot(input logic [1:0] src);
    case (src)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] op_onehot(input logic [2:0] op);
    logic [6:0] one;
    one = 7'd1;
    return (op == 3'd7) ? 7'd0 : (one << op);
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;  // must not be accepted while in reset
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Each cycle: drive, predict from the schedule model, compare on the falling edge, then record
  // any accepted command with its predicted issue cycle.
  task automatic run_random(input int cycles, input int valid_pct);
    q.delete();
    for (int i = 0; i < TblSz; i++) begin
      res_tbl[i] = 8'($urandom);
      ovf_tbl[i] = ($urandom_range(1) == 1);
    end
    for (int c = 0; c < cycles + 64; c++) begin
      int         occ;
      logic [1:0] e_st;
      logic [7:0] e_n1, e_n2, e_rd;
      logic [2:0] e_in;
      logic [6:0] e_out;
      logic       e_rv, e_re;
      cmd_valid    = (c < cycles) && ($urandom_range(99) < valid_pct);
      cmd_op       = ($urandom_range(9) == 0) ? 3'd7 : 3'($urandom_range(6));
      cmd_src      = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      cmd_a        = 8'($urandom);
      cmd_b        = 8'($urandom);
      alu_result   = res_tbl[c];
      alu_overflow = ovf_tbl[c];
      occ = 0; e_st = 2'd0; e_n1 = 8'h00; e_n2 = 8'h00; e_in = 3'b000; e_out = 7'd0;
      e_rv = 1'b0; e_rd = 8'h00; e_re = 1'b0;
      foreach (q[k]) begin
        if (q[k].accept < c && q[k].issue > c) occ++;
        if (c >= q[k].issue && c <= q[k].issue + RL) begin
          e_st  = (c == q[k].issue) ? 2'd1 : 2'd2;
          e_n1  = q[k].a;
          e_n2  = q[k].b;
          e_in  = src_onehot(q[k].src);
          e_out = op_onehot(q[k].op);
        end
        if (q[k].err && c == q[k].issue + RL + 1) begin
          e_st  = 2'd3;
          e_in  = 3'b001;
          e_out = 7'd0;
        end
        if (c == q[k].issue + RL + 1) begin
          e_rv = 1'b1;
          e_rd = q[k].data;
          e_re = q[k].err;
        end
      end
      @(negedge clk);
      check_val("cmd_ready", cmd_ready, occ < DEPTH);
      check_val("fifo_count", fifo_count, occ);
      check_val("state", state, e_st);
      check_val("in_selector", in_sel, e_in);
      check_val("out_selector", out_sel, e_out);
      if (e_st != 2'd3) begin
        check_val("num1", num1, e_n1);
        check_val("num2", num2, e_n2);
      end
      check_val("res_valid", res_valid, e_rv);
      if (e_rv) begin
        check_val("res_data", res_data, e_rd);
        check_val("res_error", res_error, e_re);
      end
      if (cmd_valid && occ < DEPTH) begin
        mcmd_t m;
        int    free_at;
        m.accept = c;
        m.op     = cmd_op;
        m.src    = cmd_src;
        m.a      = cmd_a;
        m.b      = cmd_b;
        m.issue  = c + 2;
        if (q.size() > 0) begin
          free_at = q[$].issue + RL + 1 + (q[$].err ? 2 : 0);
          if (free_at > m.issue) m.issue = free_at;
        end
        m.err  = (m.op == 3'd7) || (m.src == 2'd3) ||
                 (m.op == 3'd6 && ovf_tbl[m.issue + RL]);
        m.data = ((m.op == 3'd7) || (m.src == 2'd3)) ? 8'h00 : res_tbl[m.issue + RL];
        q.push_back(m);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_src = 2'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    alu_result = 8'h00; alu_overflow = 1'b0;

    do_reset();
    run_random(600, 40);

    // Three queued commands, then reset while the first is in WAIT
    do_reset();
    cmd_op = 3'd4; cmd_src = 2'd1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    begin
      int budget;
      budget = 20;
      @(negedge clk);
      while (state != 2'd2 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check_val("mid_wait_reached", budget > 0, 1'b1);
    end
    rst       = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("rst_res_valid", res_valid, 1'b0);
      check_val("rst_fifo_count", fifo_count, 3'd0);
      check_val("rst_state", state, 2'd0);
      check_val("rst_cmd_ready", cmd_ready, 1'b1);
    end
    @(posedge clk);
    #1;

    // Saturating stream keeps the FIFO full against back-to-back issue
    do_reset();
    run_random(300, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
